// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_prefetch_pkg;

  localparam logic        RSTN_ENABLE  = 1'b0;
  localparam logic        RSTN_DISABLE = 1'b1;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic {
    FETCH_RUN     = 1'b0,
    FETCH_DISCARD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Registered synchronous FIFO holding {pc, inst} pairs; push and pop may coincide at any fill.
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: credit-limited sequential fetch, response buffering and redirect flush.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [DATA_W-1:0] inst_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = CW + 1;

  fetch_state_e             state;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        resp_pc;
  logic [OW-1:0]            outst;
  logic [OW-1:0]            disc_cnt;
  logic [OW-1:0]            pend;
  logic [CW-1:0]            fifo_cnt;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     handshake;
  logic                     resp_ok;
  logic                     push;
  logic                     pop;
  logic [SW-1:0]            credit_used;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;

  // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a slot.
  assign credit_used = SW'(fifo_cnt) + SW'(outst);
  assign imem_req_o  = (rst != RSTN_ENABLE) && (state == FETCH_RUN) && !redirect_i &&
                       (credit_used < SW'(DEPTH)) && (outst < OW'(MAX_OUTST));
  assign imem_addr_o = fetch_pc;

  assign handshake = imem_req_o && imem_gnt_i;
  assign resp_ok   = imem_rvalid_i && (outst != '0);
  assign pend      = outst - OW'(resp_ok);
  assign push      = resp_ok && (state == FETCH_RUN) && !redirect_i;
  assign pop       = inst_valid_o && inst_ready_i;

  assign inst_valid_o = !fifo_empty;
  assign inst_pc_o    = fifo_dout[ADDR_W+DATA_W-1 -: ADDR_W];
  assign inst_o       = fifo_dout[DATA_W-1:0];

  if_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_i),
    .push  (push),
    .pop   (pop),
    .din   ({resp_pc, imem_rdata_i}),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      state    <= FETCH_RUN;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      disc_cnt <= '0;
    end else if (redirect_i) begin
      // Requests are gated during redirect, so only a same-cycle response reduces the backlog.
      fetch_pc <= redirect_pc_i;
      resp_pc  <= redirect_pc_i;
      outst    <= pend;
      disc_cnt <= pend;
      state    <= (pend == '0) ? FETCH_RUN : FETCH_DISCARD;
    end else begin
      if (handshake) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      outst <= outst + OW'(handshake) - OW'(resp_ok);
      case (state)
        FETCH_RUN: begin
          if (push) begin
            resp_pc <= resp_pc + ADDR_W'(PC_STEP);
          end
        end
        FETCH_DISCARD: begin
          if (resp_ok) begin
            disc_cnt <= disc_cnt - OW'(1);
            if (disc_cnt == OW'(1)) begin
              state <= FETCH_RUN;
            end
          end
        end
        default: state <= FETCH_RUN;
      endcase
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst == RSTN_ENABLE)
    imem_rvalid_i |-> (outst != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst == RSTN_ENABLE)
    (push && fifo_full) |-> pop);

endmodule
